// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the board's UART transmit and receive paths:
// data width, default line rate, baud counter width, frame-length constants
// and the transmitter state encoding.
//
// Build option: UART_TX_PARITY_EN adds an even-parity bit to the transmit
// frame and the corresponding TX_PARITY state.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_WIDTH        = 8;
    localparam int BAUD_RATE_DEFAULT = 9600;
    localparam int BAUD_CNT_WIDTH    = 14;

    // Frame lengths in bit periods (start + data + [parity] + stop).
    localparam int FRAME_BITS_NO_PARITY = 10;
    localparam int FRAME_BITS_PARITY    = 11;

`ifdef UART_TX_PARITY_EN
    localparam int TX_FRAME_BITS = FRAME_BITS_PARITY;
`else
    localparam int TX_FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_e;

    // Cycles per bit period; integer division truncates toward zero.
    function automatic int calcCntDiv(input int clkFreq, input int baudRate);
        return clkFreq / baudRate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Parameterised bit-period divider. Counts 0..CNT_DIV-1 while enabled and
// emits a one-cycle tick on the last count, then wraps to 0. Disabling or
// clearing forces the count back to 0.
//
// Ports:
//   clk_100MHz  in   system clock
//   rst_n       in   asynchronous active-low reset
//   enable_i    in   count while high, hold at 0 while low
//   clear_i     in   restart the bit period from 0 on the next edge
//   tick_o      out  high during the final cycle of each bit period
// ---------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CNT_DIV   = 10416,
    parameter int CNT_WIDTH = BAUD_CNT_WIDTH
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(CNT_DIV - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // The tick deliberately ignores clear_i: the owner raises clear in the
    // same cycle it reacts to the tick, so gating on it would form a loop.
    always_comb begin
        tick_o = enable_i && (cnt_q == CNT_MAX);
        cnt_d  = cnt_q + CNT_WIDTH'(1);
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// 8N1 serial transmitter, LSB first, with a one-byte holding register so
// consecutive frames leave back-to-back without an idle bit.
//
// Build option: UART_TX_PARITY_EN inserts an even-parity bit between data[7]
// and the stop bit (11-bit frame instead of 10).
//
// Parameters:
//   CLK_FREQ   system clock in Hz
//   BAUD_RATE  line rate in baud
// Ports:
//   clk_100MHz  in   system clock
//   rst_n       in   asynchronous active-low reset
//   tx_data     in   byte to send, taken when tx_valid && tx_ready
//   tx_valid    in   tx_data holds a byte
//   tx_ready    out  a byte can be accepted this cycle
//   TxD         out  registered serial line, idles high
//   busy        out  a frame is on the line (start through stop)
// ---------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = BAUD_RATE_DEFAULT
) (
    input  logic                  clk_100MHz,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  TxD,
    output logic                  busy
);

    localparam int CNT_DIV = calcCntDiv(CLK_FREQ, BAUD_RATE);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic                  baudTick;
    logic                  load;
    logic [DATA_WIDTH-1:0] loadData;
    logic                  accept;
    logic                  acceptDirect;

    // Bit-period timing; cleared on every shifter load so each frame starts
    // a fresh period, held at 0 while idle.
    uart_baud_gen #(
        .CNT_DIV   (CNT_DIV),
        .CNT_WIDTH (BAUD_CNT_WIDTH)
    ) u_baud_gen (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .enable_i   (state_q != TX_IDLE),
        .clear_i    (load),
        .tick_o     (baudTick)
    );

    assign accept = tx_valid && !hold_full_q;

    // Next-state logic. A byte reaches the shifter either straight from the
    // input (idle, or accepted exactly at the end of a stop bit with the hold
    // empty) or from the holding register at the end of a stop bit. Any other
    // accepted byte parks in the holding register.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        bit_idx_d    = bit_idx_q;
        load         = 1'b0;
        loadData     = tx_data;
        acceptDirect = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    load         = 1'b1;
                    acceptDirect = 1'b1;
                    state_d      = TX_START;
                end
            end
            TX_START: begin
                if (baudTick) begin
                    state_d   = TX_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            TX_DATA: begin
                if (baudTick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (baudTick) begin
                    state_d = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (baudTick) begin
                    if (hold_full_q) begin
                        load        = 1'b1;
                        loadData    = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = TX_START;
                    end else if (accept) begin
                        load         = 1'b1;
                        acceptDirect = 1'b1;
                        state_d      = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        if (accept && !acceptDirect) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (load) begin
            shift_d   = loadData;
            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^loadData;
`endif
        end
    end

    // Line and busy are registered from the current state, so both lag the
    // state register by one cycle and stay aligned with each other.
    always_comb begin
        txd_d  = 1'b1;
        busy_d = (state_q != TX_IDLE);
        case (state_q)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: txd_d = parity_q;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= 3'd0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_idx_q   <= bit_idx_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign tx_ready = !hold_full_q;
    assign TxD      = txd_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
// Directed bench for uart_transmitter at CLK_FREQ=960_000 (100 cycles per
// bit). Inputs change just after falling edges; outputs are observed on
// falling edges. A line monitor decodes frames from TxD into rxBytes.
// Build option: UART_TX_PARITY_EN enables the parity checks.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       TxD;
    logic       busy;

    int testsRun = 0;
    int failures = 0;

    int busyCount = 0;
    int busyRises = 0;
    int txdLowCount = 0;
    logic busyPrev = 1'b0;

    logic [7:0] rxBytes [0:63];
    logic       rxParity [0:63];
    int rxCount = 0;
    int stopBad = 0;

    uart_transmitter #(
        .CLK_FREQ  (960_000),
        .BAUD_RATE (9600)
    ) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .TxD        (TxD),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line activity counters sampled on falling edges.
    always @(negedge clk) begin
        if (busy === 1'b1) busyCount <= busyCount + 1;
        if (busy === 1'b1 && busyPrev !== 1'b1) busyRises <= busyRises + 1;
        if (TxD === 1'b0) txdLowCount <= txdLowCount + 1;
        busyPrev <= busy;
    end

    // Serial line monitor: finds a start bit and samples each bit mid-period.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && TxD === 1'b0) begin
                repeat (50) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (100) @(negedge clk);
                    b[i] = TxD;
                end
`ifdef UART_TX_PARITY_EN
                repeat (100) @(negedge clk);
                rxParity[rxCount] = TxD;
`endif
                repeat (100) @(negedge clk);
                if (TxD !== 1'b1) stopBad = stopBad + 1;
                rxBytes[rxCount] = b;
                rxCount = rxCount + 1;
            end
        end
    end

    initial begin
        #(10 * 60000);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun = testsRun + 1;
        assert (observed === expected) else begin
            failures = failures + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge with tx_ready known high; the byte is taken
    // at the next rising edge and tx_valid drops on the falling edge after.
    task automatic applyStimulus(input logic [7:0] data);
        tx_data  = data;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [0:9] f55;
        logic [0:9] fA3;
        logic [0:9] f0F;
        int b0, r0, e0, t0, idx, guard;
        logic willAccept;

        f55 = 10'b0101010101;
        fA3 = 10'b0110001011;
        f0F = 10'b0111100001;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset TxD", {31'd0, TxD}, 32'd1);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset tx_ready", {31'd0, tx_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame 0x55.
        b0 = busyCount; r0 = rxCount;
        applyStimulus(8'h55);
        repeat (50) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("frame55 bit%0d", i), {31'd0, TxD}, {31'd0, f55[i]});
            if (i < 9) repeat (100) @(negedge clk);
        end
        waitIdle();
        checkOutput("frame55 busy cycles", busyCount - b0, 32'd1000);
        checkOutput("frame55 rx byte", {24'd0, rxBytes[r0]}, 32'h55);
        checkOutput("frame55 TxD idle", {31'd0, TxD}, 32'd1);

        // 0xA3 then 0x0F queued while busy.
        b0 = busyCount; r0 = rxCount; e0 = busyRises;
        applyStimulus(8'hA3);
        repeat (9) @(negedge clk);
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("hold tx_ready low", {31'd0, tx_ready}, 32'd0);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("frameA3 bit%0d", i), {31'd0, TxD}, {31'd0, fA3[i]});
            if (i < 9) repeat (100) @(negedge clk);
        end
        repeat (49) @(negedge clk);
        checkOutput("last stop tx_ready", {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        checkOutput("after transfer tx_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("stop end TxD", {31'd0, TxD}, 32'd1);
        @(negedge clk);
        checkOutput("second start TxD", {31'd0, TxD}, 32'd0);
        repeat (49) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("frame0F bit%0d", i), {31'd0, TxD}, {31'd0, f0F[i]});
            if (i < 9) repeat (100) @(negedge clk);
        end
        waitIdle();
        checkOutput("pair busy cycles", busyCount - b0, 32'd2000);
        checkOutput("pair busy rises", busyRises - e0, 32'd1);
        checkOutput("pair rx count", rxCount - r0, 32'd2);
        checkOutput("pair rx byte0", {24'd0, rxBytes[r0]}, 32'hA3);
        checkOutput("pair rx byte1", {24'd0, rxBytes[r0+1]}, 32'h0F);

        // tx_valid held high across four bytes.
        b0 = busyCount; r0 = rxCount; e0 = busyRises;
        idx = 0; guard = 0;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        while (idx < 4 && guard < 10000) begin
            willAccept = tx_ready;
            @(negedge clk);
            guard++;
            if (willAccept) begin
                idx++;
                if (idx < 4) tx_data = 8'(idx);
                else tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        checkOutput("stream accepts", idx, 32'd4);
        waitIdle();
        checkOutput("stream busy cycles", busyCount - b0, 32'd4000);
        checkOutput("stream busy rises", busyRises - e0, 32'd1);
        checkOutput("stream rx count", rxCount - r0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("stream rx byte%0d", i), {24'd0, rxBytes[r0+i]}, i);
        end

        // Accept exactly on the last stop cycle with the hold empty.
        b0 = busyCount; r0 = rxCount; e0 = busyRises;
        applyStimulus(8'h3C);
        repeat (999) @(negedge clk);
        checkOutput("edge accept tx_ready before", {31'd0, tx_ready}, 32'd1);
        tx_data  = 8'hC5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("edge accept tx_ready after", {31'd0, tx_ready}, 32'd1);
        checkOutput("edge accept stop TxD", {31'd0, TxD}, 32'd1);
        @(negedge clk);
        checkOutput("edge accept start TxD", {31'd0, TxD}, 32'd0);
        waitIdle();
        checkOutput("edge busy cycles", busyCount - b0, 32'd2000);
        checkOutput("edge busy rises", busyRises - e0, 32'd1);
        checkOutput("edge rx byte0", {24'd0, rxBytes[r0]}, 32'h3C);
        checkOutput("edge rx byte1", {24'd0, rxBytes[r0+1]}, 32'hC5);

        // Reset during bit 4 of 0xFF with 0x12 pending.
        applyStimulus(8'hFF);
        repeat (9) @(negedge clk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("pending tx_ready", {31'd0, tx_ready}, 32'd0);
        repeat (540) @(negedge clk);
        checkOutput("pre-reset busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset TxD", {31'd0, TxD}, 32'd1);
        checkOutput("midreset busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset tx_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        b0 = busyCount; t0 = txdLowCount;
        repeat (1500) @(negedge clk);
        checkOutput("post-reset busy cycles", busyCount - b0, 32'd0);
        checkOutput("post-reset TxD low cycles", txdLowCount - t0, 32'd0);

`ifdef UART_TX_PARITY_EN
        b0 = busyCount; r0 = rxCount;
        applyStimulus(8'h07);
        waitIdle();
        checkOutput("parity07 busy cycles", busyCount - b0, 32'd1100);
        checkOutput("parity07 rx byte", {24'd0, rxBytes[r0]}, 32'h07);
        checkOutput("parity07 bit", {31'd0, rxParity[r0]}, 32'd1);
        b0 = busyCount; r0 = rxCount;
        applyStimulus(8'h03);
        waitIdle();
        checkOutput("parity03 busy cycles", busyCount - b0, 32'd1100);
        checkOutput("parity03 rx byte", {24'd0, rxBytes[r0]}, 32'h03);
        checkOutput("parity03 bit", {31'd0, rxParity[r0]}, 32'd0);
`endif

        checkOutput("stop bits high", stopBad, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter, 8N1 at 9600 baud, LSB first; the transmit counterpart of the board's UART receive path. It accepts bytes from the CPU-side I/O logic over a valid/ready handshake and drives the Basys3 TxD line. A one-byte holding register lets consecutive frames go out back-to-back with no idle gap.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate.
- clk_100MHz  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tx_data  in  8  byte to send; sampled when tx_valid && tx_ready.
- tx_valid  in  1  tx_data holds a valid byte.
- tx_ready  out  1  the block can accept a byte this cycle.
- TxD  out  1  serial line; registered; idles high.
- busy  out  1  a frame is on the line (start bit through stop bit).

## Operation
- CNT_DIV = CLK_FREQ / BAUD_RATE (integer division; 10416 at the defaults). Every bit lasts exactly CNT_DIV cycles.
- Frame: start bit (0), data[0]..data[7], optional parity bit, stop bit (1).
- States:
  - IDLE: TxD=1, baud counter held at 0.
  - START.
  - DATA: bit index 0..7.
  - PARITY: only with UART_TX_PARITY_EN.
  - STOP.
- Transitions:
  - IDLE -> START when the shifter loads.
  - START -> DATA when the bit period ends.
  - DATA -> DATA while the bit index is below 7 at the end of a bit period.
  - DATA -> PARITY or STOP after bit 7.
  - PARITY -> STOP.
  - STOP -> START if a byte is pending, otherwise STOP -> IDLE.
- Holding register (hold_full flag):
  - tx_ready = !hold_full.
  - Accept while IDLE: the byte loads directly into the shifter; hold_full stays 0.
  - Accept while not IDLE: the byte loads into the holding register; hold_full becomes 1.
  - At the last cycle of STOP with hold_full=1: the holding byte moves to the shifter and hold_full clears.
  - Accept in the same cycle as the STOP end while hold_full=0: the accepted byte goes straight to the shifter; no gap.
- tx_data is ignored when tx_valid=0. tx_valid held while tx_ready=0 causes no action.
- Reset, including mid-frame:
  - Outputs: TxD=1, busy=0, tx_ready=1.
  - State: IDLE, counters 0, hold_full=0.
  - A partial frame is abandoned and the pending byte is dropped.

## Timing
- Accept at rising edge N: TxD falls at edge N+1. busy rises at edge N+1.
- Bit k starts at N+1+k·CNT_DIV.
- Frame length: 10·CNT_DIV cycles, or 11·CNT_DIV with parity.
- busy falls one cycle after the STOP period ends, unless a pending byte keeps it high.
- Back-to-back frames: the next start bit begins on the cycle immediately after the previous stop period.
- tx_ready:
  - Falls the cycle after an accept made while busy.
  - Rises the cycle after the holding byte transfers to the shifter.
- Baud counter: 14 bits, compares against CNT_DIV-1, wraps to 0, and is cleared on every shifter load.

## Configuration
- UART_TX_PARITY_EN defined: an even parity bit (XOR of the 8 data bits) is inserted between data[7] and stop. Frame is 11 bits.
- UART_TX_PARITY_EN undefined: no PARITY state and no parity logic. Frame is 10 bits.

## Structure
- Shared package uart_pkg, also used by the receiver:
  - DATA_WIDTH=8.
  - BAUD_RATE default.
  - Frame-length constants.
  - Transmitter state enum.
- Sub-module uart_baud_gen: parameterised divider with clear input and one-cycle tick output. Reusable by the receiver's oversampler.

## Test plan
Bench uses CLK_FREQ=960_000, so CNT_DIV=100.
- Reset release, then 0x55: TxD samples at mid-bit are 0,1,0,1,0,1,0,1,0,1. busy is high for 1000 cycles.
- 0xA3 followed by 0x0F while busy:
  - tx_ready is low from the cycle after the second accept until the first stop bit ends.
  - The second start bit immediately follows the first stop bit.
  - Total busy is 2000 cycles.
- tx_valid held high continuously with bytes 0x00..0x03: four contiguous frames with no idle cycle. Each byte is accepted exactly once.
- Accept timed to coincide with the last STOP cycle (hold empty): the next start bit begins on the next cycle. tx_ready stays high.
- rst_n asserted at bit 4 of 0xFF, with 0x12 pending:
  - TxD=1, busy=0 and tx_ready=1 immediately.
  - No frame is sent after release.
- UART_TX_PARITY_EN builds: 0x07 gives parity 1 and 0x03 gives parity 0. Frame is 1100 cycles.
